// File: rtl/aes_inv_round_iter.sv
// rtl/aes_inv_round_iter.sv - iterative AES inverse cipher, one round per step
//
// Purpose: decrypts one 128-bit block at a time by iterating an inverse round
//          over a single state register.  Round keys are fetched from an
//          external combinational key store addressed by o_round_key_idx.
// Ports:
//   i_clock, i_reset_n   clock and asynchronous active-low reset
//   i_state, i_valid     ciphertext input; accepted when o_ready is high
//   o_ready              high only while idle
//   o_round_key_idx      round key address (N_ROUNDS when idle)
//   i_round_key          key for o_round_key_idx, same cycle
//   o_state, o_valid     plaintext output; held until i_ready
//   i_ready              downstream accepts o_state
// Build option: AES_INV_ROUND_ITER_SBOX_REG_EN registers InvSubBytes output,
//               making every round step two cycles long.
// Byte order: byte 0 in the MSBs, bytes column-major (byte = 4*col + row).

module aes_inv_round_iter #(
   parameter int NB_BYTE  = 8,
   parameter int N_BYTES  = 16,
   parameter int N_ROUNDS = 14
) (
   input  logic                       i_clock,
   input  logic                       i_reset_n,
   input  logic [N_BYTES*NB_BYTE-1:0] i_state,
   input  logic                       i_valid,
   output logic                       o_ready,
   output logic [3:0]                 o_round_key_idx,
   input  logic [N_BYTES*NB_BYTE-1:0] i_round_key,
   output logic [N_BYTES*NB_BYTE-1:0] o_state,
   output logic                       o_valid,
   input  logic                       i_ready
);

   localparam int         W        = N_BYTES * NB_BYTE;
   localparam logic [3:0] LAST_IDX = 4'(N_ROUNDS);

   if (!((N_ROUNDS == 10) || (N_ROUNDS == 12) || (N_ROUNDS == 14))) begin : g_bad_rounds
      $error("aes_inv_round_iter: N_ROUNDS must be 10, 12 or 14");
   end
   if ((NB_BYTE != 8) || (N_BYTES != 16)) begin : g_bad_geometry
      $error("aes_inv_round_iter: NB_BYTE must be 8 and N_BYTES must be 16");
   end

   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   // Row r is rotated right by r columns: out[r][c] = in[r][(c - r) mod 4].
   function automatic logic [W-1:0] inv_shift_rows(input logic [W-1:0] s);
      logic [W-1:0] r;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int row = 0; row < 4; row++) begin
            r[W-1-8*(4*c+row) -: 8] = s[W-1-8*(4*((c-row+4)%4)+row) -: 8];
         end
      end
      return r;
   endfunction

   function automatic logic [W-1:0] inv_sub_bytes(input logic [W-1:0] s);
      logic [W-1:0] r;
      r = '0;
      for (int b = 0; b < N_BYTES; b++) begin
         r[W-1-8*b -: 8] = INV_SBOX[s[W-1-8*b -: 8]];
      end
      return r;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Each output byte is 0e/0b/0d/09 times the column bytes starting at its own row.
   function automatic logic [W-1:0] inv_mix_columns(input logic [W-1:0] s);
      logic [W-1:0] r;
      logic [7:0]   a  [4];
      logic [7:0]   x2 [4];
      logic [7:0]   x4 [4];
      logic [7:0]   x8 [4];
      logic [7:0]   m9 [4];
      logic [7:0]   mb [4];
      logic [7:0]   md [4];
      logic [7:0]   me [4];
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int i = 0; i < 4; i++) begin
            a[i]  = s[W-1-8*(4*c+i) -: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
            m9[i] = x8[i] ^ a[i];
            mb[i] = x8[i] ^ x2[i] ^ a[i];
            md[i] = x8[i] ^ x4[i] ^ a[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
         end
         for (int i = 0; i < 4; i++) begin
            r[W-1-8*(4*c+i) -: 8] = me[i] ^ mb[(i+1)%4] ^ md[(i+2)%4] ^ m9[(i+3)%4];
         end
      end
      return r;
   endfunction

   typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

   state_t       state_q, state_d;
   logic [3:0]   cnt_q, cnt_d;
   logic [W-1:0] data_q;
   logic [W-1:0] sub_out;
   logic [W-1:0] ark_out;
   logic [W-1:0] mix_out;
   logic         step_last;   // high in the cycle that commits a round step

   assign sub_out = inv_sub_bytes(inv_shift_rows(data_q));

`ifdef AES_INV_ROUND_ITER_SBOX_REG_EN
   logic [W-1:0] sub_q;
   logic         phase_q, phase_d;

   // Phase 0 captures InvSubBytes, phase 1 adds the key and commits; the
   // counter only moves in phase 1 so the key index spans both cycles.
   assign step_last = phase_q;
   assign ark_out   = sub_q ^ i_round_key;

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         sub_q   <= '0;
         phase_q <= 1'b0;
      end else begin
         phase_q <= phase_d;
         if (((state_q == ROUND) || (state_q == FINAL)) && !phase_q) begin
            sub_q <= sub_out;
         end
      end
   end
`else
   assign step_last = 1'b1;
   assign ark_out   = sub_out ^ i_round_key;
`endif

   assign mix_out         = inv_mix_columns(ark_out);
   assign o_ready         = (state_q == IDLE);
   assign o_round_key_idx = (state_q == IDLE) ? LAST_IDX : cnt_q;

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
`ifdef AES_INV_ROUND_ITER_SBOX_REG_EN
      phase_d = 1'b0;
      if ((state_q == ROUND) || (state_q == FINAL)) begin
         phase_d = ~phase_q;
      end
`endif
      case (state_q)
         IDLE: begin
            if (i_valid) begin
               state_d = ROUND;
               cnt_d   = LAST_IDX - 4'd1;
            end
         end
         ROUND: begin
            if (step_last) begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_d = FINAL;
               end
            end
         end
         FINAL: begin
            if (step_last) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (i_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // o_state is only written in FINAL so it keeps the last plaintext while idle.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         data_q  <= '0;
         o_state <= '0;
         o_valid <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (i_valid) begin
                  data_q <= i_state ^ i_round_key;
               end
            end
            ROUND: begin
               if (step_last) begin
                  data_q <= mix_out;
               end
            end
            FINAL: begin
               if (step_last) begin
                  o_state <= ark_out;
                  o_valid <= 1'b1;
               end
            end
            DONE: begin
               if (i_ready) begin
                  o_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
